// File: rtl/isq_issue_sel_if.sv
// Issue-slot bundle between the issue selector and the functional units.
// The selector drives valid/index/payload per slot; each FU returns its ready.
interface isq_issue_sel_if #(
  parameter int unsigned ISSUE_PORT = 2,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned INST_WIDTH = 67
);
  logic [ISSUE_PORT-1:0]            iss_vld;
  logic [ISSUE_PORT-1:0]            iss_rdy;
  logic [IDX_W*ISSUE_PORT-1:0]      iss_idx_flat;
  logic [INST_WIDTH*ISSUE_PORT-1:0] iss_inst_flat;

  modport master (
    output iss_vld,
    output iss_idx_flat,
    output iss_inst_flat,
    input  iss_rdy
  );

  modport slave (
    input  iss_vld,
    input  iss_idx_flat,
    input  iss_inst_flat,
    output iss_rdy
  );
endinterface

// File: rtl/isq_issue_sel.sv
// Issue-queue read side: picks up to ISSUE_PORT ready lines in age order from old_ptr,
// holds them in registered slots until the FU handshakes, then pulses clr_val back to isq.
module isq_issue_sel #(
  parameter int unsigned ISQ_DEPTH        = 64,
  parameter int unsigned ISQ_IDX_BITS_NUM = 6,
  parameter int unsigned INST_WIDTH       = 67,
  parameter int unsigned ISSUE_PORT       = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [(INST_WIDTH+2+ISQ_IDX_BITS_NUM)*ISQ_DEPTH-1:0]   isq_out_flat,
  input  logic [ISQ_IDX_BITS_NUM-1:0]                            old_ptr,
  input  logic                                                   flush,
  output logic [ISQ_DEPTH-1:0]                                   clr_val,
  isq_issue_sel_if.master                                        iss
);
  localparam int unsigned IW = ISQ_IDX_BITS_NUM;
  localparam int unsigned LW = INST_WIDTH + 2 + IW;

  logic [LW-1:0]         line [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0]  val_v;
  logic [ISQ_DEPTH-1:0]  ready_v;
  logic [ISQ_DEPTH-1:0]  issued_q, issued_d;
  logic [ISQ_DEPTH-1:0]  clr_q, clr_d;
  logic [ISSUE_PORT-1:0] vld_q, vld_d;
  logic [ISSUE_PORT-1:0] free, avail, load;
  logic [IW-1:0]         idx_q [ISSUE_PORT];
  logic [IW-1:0]         idx_d [ISSUE_PORT];
  logic [INST_WIDTH-1:0] inst_q [ISSUE_PORT];
  logic [INST_WIDTH-1:0] inst_d [ISSUE_PORT];
  logic [IW-1:0]         load_pos [ISSUE_PORT];
  logic [IW-1:0]         pos;
  logic                  taken;

  always_comb begin
    for (int unsigned i = 0; i < ISQ_DEPTH; i++) begin
      line[i]    = isq_out_flat[LW*i +: LW];
      val_v[i]   = line[i][INST_WIDTH+1];
      ready_v[i] = line[i][INST_WIDTH+1] & ~line[i][INST_WIDTH] & ~issued_q[i];
    end
  end

  // Circular age-ordered scan; each ready line claims the lowest still-unclaimed free slot.
  always_comb begin
    free  = ~vld_q | iss.iss_rdy;
    avail = free;
    load  = '0;
    pos   = '0;
    taken = 1'b0;
    for (int unsigned p = 0; p < ISSUE_PORT; p++) begin
      load_pos[p] = '0;
    end
    for (int unsigned k = 0; k < ISQ_DEPTH; k++) begin
      pos   = old_ptr + IW'(k);
      taken = 1'b0;
      if (ready_v[pos]) begin
        for (int unsigned p = 0; p < ISSUE_PORT; p++) begin
          if (avail[p] && !taken) begin
            load[p]     = 1'b1;
            load_pos[p] = pos;
            avail[p]    = 1'b0;
            taken       = 1'b1;
          end
        end
      end
    end
    if (flush) begin
      load = '0;
    end
  end

  // issued tracks lines already handed out; it drops once isq shows the line invalid,
  // and a same-edge load sets it again (set applied after clear).
  always_comb begin
    vld_d    = load | (vld_q & ~iss.iss_rdy);
    issued_d = issued_q & val_v;
    clr_d    = '0;
    for (int unsigned p = 0; p < ISSUE_PORT; p++) begin
      idx_d[p]  = idx_q[p];
      inst_d[p] = inst_q[p];
      if (load[p]) begin
        idx_d[p]              = line[load_pos[p]][LW-1 -: IW];
        inst_d[p]             = line[load_pos[p]][INST_WIDTH-1:0];
        issued_d[load_pos[p]] = 1'b1;
      end
      if (vld_q[p] && iss.iss_rdy[p]) begin
        clr_d[idx_q[p]] = 1'b1;
      end
    end
    if (flush) begin
      vld_d    = '0;
      issued_d = '0;
      clr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      issued_q <= '0;
      clr_q    <= '0;
      for (int unsigned p = 0; p < ISSUE_PORT; p++) begin
        idx_q[p]  <= '0;
        inst_q[p] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      issued_q <= issued_d;
      clr_q    <= clr_d;
      for (int unsigned p = 0; p < ISSUE_PORT; p++) begin
        idx_q[p]  <= idx_d[p];
        inst_q[p] <= inst_d[p];
      end
    end
  end

  assign clr_val     = clr_q;
  assign iss.iss_vld = vld_q;

  for (genvar p = 0; p < ISSUE_PORT; p++) begin : g_slot_out
    assign iss.iss_idx_flat[IW*p +: IW]                 = idx_q[p];
    assign iss.iss_inst_flat[INST_WIDTH*p +: INST_WIDTH] = inst_q[p];
  end
endmodule

// File: tb/tb_isq_issue_sel.sv
// Bench for isq_issue_sel: table of single-shot select vectors through a scoreboard,
// plus hand sequences for reset, slot hold, wait bit, flush and reset during handshake.
module tb_isq_issue_sel;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned IW    = 6;
  localparam int unsigned INSTW = 67;
  localparam int unsigned NP    = 2;
  localparam int unsigned LW    = INSTW + 2 + IW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LW*DEPTH-1:0] bus;
  logic [IW-1:0]     old_ptr;
  logic              flush;
  logic [DEPTH-1:0]  clr_val;
  logic [DEPTH-1:0]  val_m, wat_m;

  always #5 clk = ~clk;

  isq_issue_sel_if #(.ISSUE_PORT(NP), .IDX_W(IW), .INST_WIDTH(INSTW)) iss_if ();

  isq_issue_sel #(
    .ISQ_DEPTH(DEPTH), .ISQ_IDX_BITS_NUM(IW), .INST_WIDTH(INSTW), .ISSUE_PORT(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .isq_out_flat(bus), .old_ptr(old_ptr),
    .flush(flush), .clr_val(clr_val), .iss(iss_if)
  );

  typedef struct {
    string      name;
    logic [5:0] ptr;
    logic [63:0] val;
    logic [63:0] wat;
    logic [1:0] vld1;
    int         l0;
    int         l1;
    logic [1:0] vld2;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];
  vec_t e;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] expm;

  // idx field deliberately differs from the line position
  function automatic logic [IW-1:0] idx_of(int l);
    return IW'(l) ^ 6'h2A;
  endfunction

  function automatic logic [INSTW-1:0] pay(int l);
    return {3'(l), 32'hC0DE_0000 + 32'(l), 32'(l * 13 + 1)};
  endfunction

  function automatic logic [63:0] m1(int l);
    return 64'd1 << l;
  endfunction

  always_comb begin
    bus = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus[LW*i +: LW] = {idx_of(i), val_m[i], wat_m[i], pay(i)};
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slot(input string nm, input int p, input int l);
    chk({nm, "_idx"}, iss_if.iss_idx_flat[IW*p +: IW], idx_of(l));
    chk({nm, "_inst"}, iss_if.iss_inst_flat[INSTW*p +: INSTW], pay(l));
  endtask

  task automatic clean();
    val_m = '0;
    wat_m = '0;
    flush = 1'b0;
    iss_if.iss_rdy = '1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"two_ready", 6'd0,  m1(3) | m1(5),           64'd0, 2'b11, 3,  5,  2'b00};
    vecs[1] = '{"wrap",      6'd62, m1(1) | m1(63),          64'd0, 2'b11, 63, 1,  2'b00};
    vecs[2] = '{"waiting",   6'd0,  m1(9),                   m1(9), 2'b00, 0,  0,  2'b00};
    vecs[3] = '{"one_back",  6'd11, m1(10),                  64'd0, 2'b01, 10, 0,  2'b00};
    vecs[4] = '{"all_ready", 6'd60, '1,                      64'd0, 2'b11, 60, 61, 2'b11};
    vecs[5] = '{"three",     6'd45, m1(20) | m1(40) | m1(50), 64'd0, 2'b11, 50, 20, 2'b01};
    vecs[6] = '{"empty",     6'd7,  64'd0,                   64'd0, 2'b00, 0,  0,  2'b00};
    vecs[7] = '{"ends",      6'd0,  m1(0) | m1(63),          64'd0, 2'b11, 0,  63, 2'b00};

    rst_n = 1'b0;
    val_m = '0;
    wat_m = '0;
    flush = 1'b0;
    old_ptr = '0;
    iss_if.iss_rdy = '1;
    repeat (2) @(negedge clk);
    chk("rst_vld", iss_if.iss_vld, 0);
    chk("rst_idx", iss_if.iss_idx_flat, 0);
    chk("rst_inst", iss_if.iss_inst_flat, 0);
    chk("rst_clr", clr_val, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle", {iss_if.iss_vld, clr_val}, 0);
    end

    for (int v = 0; v < 8; v++) begin
      clean();
      old_ptr = vecs[v].ptr;
      val_m   = vecs[v].val;
      wat_m   = vecs[v].wat;
      sb.push_back(vecs[v]);
      tick();
      e = sb.pop_front();
      chk({e.name, "_vld1"}, iss_if.iss_vld, e.vld1);
      expm = '0;
      if (e.vld1[0]) begin
        check_slot({e.name, "_s0"}, 0, e.l0);
        expm |= m1(idx_of(e.l0));
      end
      if (e.vld1[1]) begin
        check_slot({e.name, "_s1"}, 1, e.l1);
        expm |= m1(idx_of(e.l1));
      end
      tick();
      chk({e.name, "_clr"}, clr_val, expm);
      chk({e.name, "_vld2"}, iss_if.iss_vld, e.vld2);
    end

    // slot 0 stalled by its FU while slot 1 keeps flowing
    clean();
    iss_if.iss_rdy = 2'b10;
    old_ptr = '0;
    val_m = m1(4);
    tick();
    chk("hold_load_vld", iss_if.iss_vld, 2'b01);
    check_slot("hold_load", 0, 4);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_vld", iss_if.iss_vld, 2'b01);
      chk("hold_idx", iss_if.iss_idx_flat[IW-1:0], idx_of(4));
      chk("hold_clr", clr_val, 0);
    end
    val_m = val_m | m1(7);
    tick();
    chk("hold_l7_vld", iss_if.iss_vld, 2'b11);
    check_slot("hold_s0", 0, 4);
    check_slot("hold_s1", 1, 7);
    tick();
    chk("hold_clr7", clr_val, m1(idx_of(7)));
    chk("hold_vld_after7", iss_if.iss_vld, 2'b01);
    val_m[7] = 1'b0;
    iss_if.iss_rdy = 2'b11;
    tick();
    chk("hold_clr4", clr_val, m1(idx_of(4)));
    chk("hold_vld_done", iss_if.iss_vld, 2'b00);
    val_m[4] = 1'b0;
    tick();
    chk("hold_clr_pulse", clr_val, 0);

    // wait bit blocks selection until it drops
    clean();
    old_ptr = 6'd5;
    val_m = m1(9);
    wat_m = m1(9);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wat_blocked", iss_if.iss_vld, 2'b00);
    end
    wat_m = '0;
    tick();
    chk("wat_vld", iss_if.iss_vld, 2'b01);
    check_slot("wat_s0", 0, 9);

    // flush while both slots handshake
    clean();
    iss_if.iss_rdy = 2'b00;
    old_ptr = '0;
    val_m = m1(12) | m1(13);
    tick();
    chk("fl_full", iss_if.iss_vld, 2'b11);
    iss_if.iss_rdy = 2'b11;
    flush = 1'b1;
    tick();
    chk("fl_vld", iss_if.iss_vld, 2'b00);
    chk("fl_clr", clr_val, 0);
    flush = 1'b0;
    tick();
    chk("fl_resel_vld", iss_if.iss_vld, 2'b11);
    check_slot("fl_s0", 0, 12);
    check_slot("fl_s1", 1, 13);
    tick();
    chk("fl_resel_clr", clr_val, m1(idx_of(12)) | m1(idx_of(13)));

    // reset while a slot is about to handshake
    clean();
    old_ptr = '0;
    val_m = m1(20);
    tick();
    chk("mr_vld", iss_if.iss_vld, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mr_async", {iss_if.iss_vld, clr_val}, 0);
    val_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_no_clr", clr_val, 0);
    tick();
    chk("mr_idle", {iss_if.iss_vld, clr_val}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
